// File: rtl/ifu_mem_rsp.sv
// ifu_mem_rsp: instruction-memory stand-in behind the IFU cache miss port.
// Line requests are queued in a small in-order FIFO. Each one is answered from
// an internal line store after a fixed latency, as a single-cycle tagged
// response. A preload port fills the store; the store is never reset.
//
// Request handshake: a request is taken on a rising edge when
// mem_reqTagValidIn=1 and mem_reqReadyOut=1. mem_reqReadyOut depends only on
// the registered FIFO count, so it never reacts combinationally to valid.
// A request presented while ready is low is dropped and sets the sticky
// ovf_errOut. Responses have no backpressure: mem_rspInsLineValidOut pulses
// for one cycle and the consumer must sample it in that cycle.
module ifu_mem_rsp #(
    parameter int TAG_WIDTH  = 6,
    parameter int LINE_WIDTH = 32,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic [TAG_WIDTH-1:0]  mem_reqTagIn,
    input  logic                  mem_reqTagValidIn,
    output logic                  mem_reqReadyOut,
    output logic [TAG_WIDTH-1:0]  mem_rspTagOut,
    output logic [LINE_WIDTH-1:0] mem_rspInsLineOut,
    output logic                  mem_rspInsLineValidOut,
    input  logic                  ld_wrEnIn,
    input  logic [TAG_WIDTH-1:0]  ld_wrTagIn,
    input  logic [LINE_WIDTH-1:0] ld_wrLineIn,
    output logic                  ovf_errOut,
    output logic                  busyOut,
    output logic [1:0]            dbg_stateOut
);

    // Store is indexed directly by tag.
    localparam int STORE_LINES = 1 << TAG_WIDTH;
    // FIFO pointer and count widths; count needs one extra bit to encode "full".
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    // The WAIT counter starts at LATENCY-1 and the capture edge is the one
    // that finds it at zero, giving LATENCY edges spent in WAIT.
    localparam logic [3:0]       LAT_RELOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Line store and request queue storage (data only, no reset needed).
    logic [LINE_WIDTH-1:0] r_store [STORE_LINES];
    logic [TAG_WIDTH-1:0]  r_fifo  [FIFO_DEPTH];

    // Queue bookkeeping.
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Sequencer state.
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [TAG_WIDTH-1:0]  r_cur_tag;

    // Registered response outputs and sticky error.
    logic [TAG_WIDTH-1:0]  r_rsp_tag;
    logic [LINE_WIDTH-1:0] r_rsp_line;
    logic                  r_rsp_valid;
    logic                  r_ovf;

    logic                  w_ready;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Ready comes from the registered count only: a full queue refuses a push
    // even on an edge where the sequencer pops.
    assign w_ready = (r_count < FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = mem_reqTagValidIn & w_ready;
    // The sequencer takes the head only from IDLE or RESP; a push into an empty
    // queue is therefore seen one edge later, never popped on the same edge.
    assign w_pop   = ~w_empty & ((r_state == ST_IDLE) | (r_state == ST_RESP));

    // Preload write port; contents persist across reset.
    always_ff @(posedge Clock) begin
        if (ld_wrEnIn) begin
            r_store[ld_wrTagIn] <= ld_wrLineIn;
        end
    end

    // Queue data write at the tail on an accepted request.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_reqTagIn;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Response sequencer: pop head, wait out the latency, emit one-cycle response.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_cur_tag   <= '0;
            r_rsp_tag   <= '0;
            r_rsp_line  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cur_tag <= r_fifo[r_rd_ptr];
                        r_cnt     <= LAT_RELOAD;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Store read uses the pre-edge contents, so a preload
                        // write to the same tag on this edge is not seen.
                        r_rsp_tag   <= r_cur_tag;
                        r_rsp_line  <= r_store[r_cur_tag];
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_pop) begin
                        r_cur_tag <= r_fifo[r_rd_ptr];
                        r_cnt     <= LAT_RELOAD;
                        r_state   <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a request offered while the queue is full is dropped.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_ovf <= 1'b0;
        end else if (mem_reqTagValidIn & ~w_ready) begin
            r_ovf <= 1'b1;
        end
    end

    assign mem_reqReadyOut        = w_ready;
    assign mem_rspTagOut          = r_rsp_tag;
    assign mem_rspInsLineOut      = r_rsp_line;
    assign mem_rspInsLineValidOut = r_rsp_valid;
    assign ovf_errOut             = r_ovf;
    assign busyOut                = ~w_empty | (r_state != ST_IDLE);
    assign dbg_stateOut           = r_state;

endmodule

// File: tb/tb_ifu_mem_rsp.sv
// Testbench for ifu_mem_rsp: directed vector table, hand-written corner
// sequences and randomized traffic, all checked every cycle against a
// schedule-level reference model (response edge = max(accept + L + 1,
// previous response + L + 1); a request sits in the queue until L edges
// before its response).
module tb_ifu_mem_rsp;

    localparam int TW    = 6;
    localparam int LW    = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic          Clock;
    logic          Rst;
    logic [TW-1:0] mem_reqTagIn;
    logic          mem_reqTagValidIn;
    logic          mem_reqReadyOut;
    logic [TW-1:0] mem_rspTagOut;
    logic [LW-1:0] mem_rspInsLineOut;
    logic          mem_rspInsLineValidOut;
    logic          ld_wrEnIn;
    logic [TW-1:0] ld_wrTagIn;
    logic [LW-1:0] ld_wrLineIn;
    logic          ovf_errOut;
    logic          busyOut;
    logic [1:0]    dbg_stateOut;

    ifu_mem_rsp #(
        .TAG_WIDTH (TW),
        .LINE_WIDTH(LW),
        .LATENCY   (LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .Clock                 (Clock),
        .Rst                   (Rst),
        .mem_reqTagIn          (mem_reqTagIn),
        .mem_reqTagValidIn     (mem_reqTagValidIn),
        .mem_reqReadyOut       (mem_reqReadyOut),
        .mem_rspTagOut         (mem_rspTagOut),
        .mem_rspInsLineOut     (mem_rspInsLineOut),
        .mem_rspInsLineValidOut(mem_rspInsLineValidOut),
        .ld_wrEnIn             (ld_wrEnIn),
        .ld_wrTagIn            (ld_wrTagIn),
        .ld_wrLineIn           (ld_wrLineIn),
        .ovf_errOut            (ovf_errOut),
        .busyOut               (busyOut),
        .dbg_stateOut          (dbg_stateOut)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model state ----------------
    int            n_checks;
    int            n_fail;
    int            edge_no;
    logic [LW-1:0] m_store [1 << TW];
    logic [TW-1:0] exp_q[$];
    int            exp_edge_q[$];
    int            last_resp_edge;
    bit            m_ovf;
    logic [TW-1:0] m_last_tag;
    logic [LW-1:0] m_last_line;

    int            log_edge[$];
    logic [TW-1:0] log_tag[$];
    logic [LW-1:0] log_line[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: edge=%0d got=%0h expected=%0h", name, edge_no, act, exp);
        end
    endtask

    function automatic int fifo_count(input int k);
        int c;
        c = 0;
        foreach (exp_edge_q[i]) begin
            if (exp_edge_q[i] - LAT > k) c++;
        end
        return c;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_edge_q.delete();
        last_resp_edge = -1000;
        m_ovf          = 1'b0;
        m_last_tag     = '0;
        m_last_line    = '0;
    endtask

    task automatic clear_log();
        log_edge.delete();
        log_tag.delete();
        log_line.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input bit v, input logic [TW-1:0] t);
        mem_reqTagValidIn = v;
        mem_reqTagIn      = t;
    endtask

    task automatic set_wr(input bit e, input logic [TW-1:0] t, input logic [LW-1:0] l);
        ld_wrEnIn   = e;
        ld_wrTagIn  = t;
        ld_wrLineIn = l;
    endtask

    // One clock: apply the currently driven inputs, advance the model, check all outputs.
    task automatic step();
        bit            v;
        bit            we;
        logic [TW-1:0] t;
        logic [TW-1:0] wt;
        logic [LW-1:0] wl;
        int            cnt_prev;
        int            re;
        bit            exp_valid;
        bit            exp_busy;
        logic [TW-1:0] et;
        logic [LW-1:0] el;
        v  = mem_reqTagValidIn;
        t  = mem_reqTagIn;
        we = ld_wrEnIn;
        wt = ld_wrTagIn;
        wl = ld_wrLineIn;
        cnt_prev = fifo_count(edge_no);
        @(posedge Clock);
        edge_no++;
        #1;
        exp_valid = 1'b0;
        et = m_last_tag;
        el = m_last_line;
        if (exp_q.size() > 0 && exp_edge_q[0] == edge_no) begin
            exp_valid = 1'b1;
            et = exp_q[0];
            el = m_store[et];
        end
        if (v) begin
            if (cnt_prev < DEPTH) begin
                re = edge_no + LAT + 1;
                if (last_resp_edge + LAT + 1 > re) re = last_resp_edge + LAT + 1;
                last_resp_edge = re;
                exp_q.push_back(t);
                exp_edge_q.push_back(re);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (we) m_store[wt] = wl;
        exp_busy = (exp_q.size() > 0);
        if (exp_valid) begin
            void'(exp_q.pop_front());
            void'(exp_edge_q.pop_front());
            m_last_tag  = et;
            m_last_line = el;
        end
        check("rsp_valid", 64'(mem_rspInsLineValidOut), 64'(exp_valid));
        check("rsp_tag",   64'(mem_rspTagOut),          64'(et));
        check("rsp_line",  64'(mem_rspInsLineOut),      64'(el));
        check("ready",     64'(mem_reqReadyOut),        64'(fifo_count(edge_no) < DEPTH));
        check("busy",      64'(busyOut),                64'(exp_busy));
        check("ovf",       64'(ovf_errOut),             64'(m_ovf));
        if (mem_rspInsLineValidOut === 1'b1) begin
            log_edge.push_back(edge_no);
            log_tag.push_back(mem_rspTagOut);
            log_line.push_back(mem_rspInsLineOut);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ready"}, 64'(mem_reqReadyOut),        64'(1));
        check({pfx, "_tag"},   64'(mem_rspTagOut),          64'(0));
        check({pfx, "_line"},  64'(mem_rspInsLineOut),      64'(0));
        check({pfx, "_valid"}, 64'(mem_rspInsLineValidOut), 64'(0));
        check({pfx, "_ovf"},   64'(ovf_errOut),             64'(0));
        check({pfx, "_busy"},  64'(busyOut),                64'(0));
        check({pfx, "_state"}, 64'(dbg_stateOut),           64'(0));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        set_req(1'b0, '0);
        set_wr(1'b0, '0, '0);
        #1;
        Rst = 1'b1;
        #1;
        model_reset();
        check_reset_vals("async_rst");
        @(posedge Clock);
        edge_no++;
        #1;
        Rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        set_req(1'b0, '0);
        set_wr(1'b0, '0, '0);
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_bound", 64'(exp_q.size()), 64'(0));
        step();
        step();
    endtask

    task automatic wait_log(input int want, input int bound);
        int n;
        n = 0;
        while (log_tag.size() < want && n < bound) begin
            step();
            n++;
        end
        check("rsp_count", 64'(log_tag.size()), 64'(want));
    endtask

    // ---------------- tests ----------------
    typedef struct {
        logic [TW-1:0] tag;
        logic [LW-1:0] line;
        int            exp_lat;
        logic [TW-1:0] exp_tag;
        logic [LW-1:0] exp_line;
    } vec_t;

    task automatic test_table();
        vec_t vecs[4];
        int   acc;
        vecs[0] = '{tag: 6'd1,  line: 32'hDEADBEEF, exp_lat: 4, exp_tag: 6'd1,  exp_line: 32'hDEADBEEF};
        vecs[1] = '{tag: 6'd0,  line: 32'h00000001, exp_lat: 4, exp_tag: 6'd0,  exp_line: 32'h00000001};
        vecs[2] = '{tag: 6'd63, line: 32'hFFFFFFFF, exp_lat: 4, exp_tag: 6'd63, exp_line: 32'hFFFFFFFF};
        vecs[3] = '{tag: 6'd42, line: 32'hA5A55A5A, exp_lat: 4, exp_tag: 6'd42, exp_line: 32'hA5A55A5A};
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, vecs[i].tag, vecs[i].line);
            step();
            set_wr(1'b0, '0, '0);
            step();
            clear_log();
            set_req(1'b1, vecs[i].tag);
            step();
            acc = edge_no;
            set_req(1'b0, '0);
            wait_log(1, 20);
            if (log_tag.size() >= 1) begin
                check("vec_latency", 64'(log_edge[0] - acc), 64'(vecs[i].exp_lat));
                check("vec_tag",     64'(log_tag[0]),        64'(vecs[i].exp_tag));
                check("vec_line",    64'(log_line[0]),       64'(vecs[i].exp_line));
            end
            step();
            check("vec_busy_after", 64'(busyOut), 64'(0));
        end
    endtask

    task automatic test_back_to_back();
        int            exp_off[3];
        logic [LW-1:0] exp_ln[3];
        int            acc;
        exp_off = '{4, 8, 12};
        exp_ln  = '{32'hDEADBEEF, 32'hCAFEBABE, 32'hFEEDC0DE};
        drain();
        for (int i = 0; i < 3; i++) begin
            set_wr(1'b1, TW'(i + 1), exp_ln[i]);
            step();
        end
        set_wr(1'b0, '0, '0);
        step();
        clear_log();
        set_req(1'b1, 6'd1);
        step();
        acc = edge_no;
        set_req(1'b1, 6'd2);
        step();
        set_req(1'b1, 6'd3);
        step();
        set_req(1'b0, '0);
        wait_log(3, 40);
        for (int i = 0; i < 3; i++) begin
            if (log_tag.size() > i) begin
                check("b2b_offset", 64'(log_edge[i] - acc), 64'(exp_off[i]));
                check("b2b_tag",    64'(log_tag[i]),        64'(i + 1));
                check("b2b_line",   64'(log_line[i]),       64'(exp_ln[i]));
            end
        end
    endtask

    task automatic test_fill();
        int nxt;
        int acc0;
        int first_low;
        bit drove;
        drain();
        clear_log();
        nxt       = 0;
        acc0      = -1;
        first_low = -1;
        for (int n = 0; n < 120 && log_tag.size() < 10; n++) begin
            drove = (nxt < 10) && (mem_reqReadyOut === 1'b1);
            set_req(drove, TW'(nxt));
            step();
            if (drove) begin
                if (acc0 < 0) acc0 = edge_no;
                nxt++;
            end
            if (acc0 >= 0 && first_low < 0 && mem_reqReadyOut === 1'b0) first_low = edge_no - acc0;
        end
        set_req(1'b0, '0);
        check("fill_count", 64'(log_tag.size()), 64'(10));
        check("fill_ready_low_at", 64'(first_low), 64'(4));
        for (int i = 0; i < 10; i++) begin
            if (log_tag.size() > i) check("fill_order", 64'(log_tag[i]), 64'(i));
        end
        check("fill_no_ovf", 64'(ovf_errOut), 64'(0));
    endtask

    task automatic test_collision();
        int acc;
        drain();
        set_wr(1'b1, 6'd5, 32'h11111111);
        step();
        set_wr(1'b0, '0, '0);
        step();
        clear_log();
        set_req(1'b1, 6'd5);
        step();
        acc = edge_no;
        set_req(1'b0, '0);
        step();
        step();
        step();
        set_wr(1'b1, 6'd5, 32'h22222222);
        step();
        set_wr(1'b0, '0, '0);
        check("coll_count", 64'(log_tag.size()), 64'(1));
        if (log_tag.size() >= 1) begin
            check("coll_edge", 64'(log_edge[0] - acc), 64'(4));
            check("coll_old",  64'(log_line[0]),       64'(32'h11111111));
        end
        drain();
        clear_log();
        set_req(1'b1, 6'd5);
        step();
        set_req(1'b0, '0);
        wait_log(1, 20);
        if (log_tag.size() >= 1) check("coll_new", 64'(log_line[0]), 64'(32'h22222222));
    endtask

    task automatic test_overflow();
        logic [TW-1:0] exp_tags[6];
        exp_tags = '{6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd26};
        drain();
        clear_log();
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, TW'(20 + i));
            step();
            if (i == 4) check("ovf_before", 64'(ovf_errOut), 64'(0));
            if (i == 5) check("ovf_rise",   64'(ovf_errOut), 64'(1));
        end
        set_req(1'b0, '0);
        wait_log(6, 80);
        for (int i = 0; i < 6; i++) begin
            if (log_tag.size() > i) check("ovf_accepted_tag", 64'(log_tag[i]), 64'(exp_tags[i]));
        end
        drain();
        check("ovf_sticky", 64'(ovf_errOut), 64'(1));
        for (int i = 0; i < log_tag.size(); i++) begin
            if (log_tag[i] == 6'd25 || log_tag[i] == 6'd27) check("ovf_dropped_seen", 64'(log_tag[i]), 64'(0));
        end
    endtask

    task automatic test_reset_mid();
        drain();
        clear_log();
        set_req(1'b1, 6'd2);
        step();
        set_req(1'b0, '0);
        step();
        step();
        check("rst_in_wait_busy", 64'(busyOut), 64'(1));
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("rst_no_rsp", 64'(log_tag.size()), 64'(0));
        set_req(1'b1, 6'd2);
        step();
        set_req(1'b0, '0);
        wait_log(1, 20);
        if (log_tag.size() >= 1) begin
            check("rst_store_kept_tag",  64'(log_tag[0]),  64'(2));
            check("rst_store_kept_line", 64'(log_line[0]), 64'(32'hCAFEBABE));
        end
    endtask

    task automatic rand_phase(input int n, input bit honour);
        bit v;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(0, 99) < 60);
            if (honour && mem_reqReadyOut !== 1'b1) v = 1'b0;
            set_req(v, TW'($urandom_range(0, (1 << TW) - 1)));
            set_wr($urandom_range(0, 3) == 0, TW'($urandom_range(0, (1 << TW) - 1)), $urandom);
            step();
        end
        set_req(1'b0, '0);
        set_wr(1'b0, '0, '0);
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_no  = 0;
        Rst      = 1'b1;
        set_req(1'b0, '0);
        set_wr(1'b0, '0, '0);
        model_reset();
        #1;
        check_reset_vals("por");
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Rst = 1'b0;

        for (int i = 0; i < (1 << TW); i++) begin
            set_wr(1'b1, TW'(i), $urandom);
            step();
        end
        set_wr(1'b0, '0, '0);
        step();

        test_table();
        test_back_to_back();
        test_fill();
        test_collision();
        test_overflow();
        test_reset_mid();

        drain();
        rand_phase(300, 1'b1);
        drain();
        check("rand_honour_no_ovf", 64'(ovf_errOut), 64'(0));
        rand_phase(250, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_mem_rsp.md
# ifu_mem_rsp

Memory-side responder for the IFU instruction cache miss interface. It accepts line requests (`mem_reqTag*`) issued by `ifu_cache` and queues them in a small in-order FIFO. Each request is served from an internal instruction-line store after a fixed, parameterised latency, and the result is returned as a single-cycle tagged line response (`mem_rspTag*`, `mem_rspInsLine*`). A preload write port fills the store from the testbench or boot logic. The block stands in for the instruction memory behind the cache.

## Interface
- `TAG_WIDTH`, 6: request/response tag width; the store depth is 2**TAG_WIDTH lines, indexed directly by tag.
- `LINE_WIDTH`, 32: instruction line width.
- `LATENCY`, 3: wait cycles between dequeue and response; legal range 1..15.
- `FIFO_DEPTH`, 4: request queue entries; must be a power of 2, at least 2.

- `Clock`  in  1  single clock, rising edge.
- `Rst`  in  1  reset; asynchronous and active-high.
- `mem_reqTagIn`  in  TAG_WIDTH  requested line tag.
- `mem_reqTagValidIn`  in  1  request valid.
- `mem_reqReadyOut`  out  1  queue can accept a request.
- `mem_rspTagOut`  out  TAG_WIDTH  tag of the returned line.
- `mem_rspInsLineOut`  out  LINE_WIDTH  returned line.
- `mem_rspInsLineValidOut`  out  1  response valid, one-cycle pulse.
- `ld_wrEnIn`  in  1  preload write enable.
- `ld_wrTagIn`  in  TAG_WIDTH  preload line index.
- `ld_wrLineIn`  in  LINE_WIDTH  preload data.
- `ovf_errOut`  out  1  sticky flag: a request arrived while `mem_reqReadyOut` was low.
- `busyOut`  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
- **Store:** register array of 2**TAG_WIDTH × LINE_WIDTH. It has no reset, so contents survive `Rst`. A write lands at the rising edge when `ld_wrEnIn`=1.
- **FIFO:** in-order, FIFO_DEPTH entries. Count width is log2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- **Accept:** a push happens when `mem_reqTagValidIn`=1 and `mem_reqReadyOut`=1.
- **Ready:** `mem_reqReadyOut` = (count < FIFO_DEPTH). It is decoded combinationally from the registered count only. When the FIFO is full, a push is rejected even if a pop occurs in the same cycle.
- **Overflow:** valid with ready low drops the request and sets `ovf_errOut`. It stays set until `Rst`.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: if FIFO non-empty → pop head into `cur_tag`, load `cnt`=LATENCY-1, go to WAIT.
  - WAIT: if `cnt`≠0, decrement. If `cnt`=0, register `mem_rspTagOut`=`cur_tag` and `mem_rspInsLineOut`=store[`cur_tag`], set valid=1, go to RESP.
  - RESP: valid drops at the next edge. If FIFO non-empty → pop, reload `cnt`, go to WAIT; otherwise go to IDLE.
- **Collision:** a preload write to `cur_tag` on the same edge that captures the line returns the old data. A write on any earlier edge is visible in the response.
- **Output hold:** `mem_rspTagOut` and `mem_rspInsLineOut` hold their last values while valid=0.
- **Simultaneous push and pop:** both occur and the count is unchanged. A push into an empty FIFO is not popped until the following edge.

## Timing
- **Reset values:** `mem_reqReadyOut`=1, `mem_rspTagOut`=0, `mem_rspInsLineOut`=0, `mem_rspInsLineValidOut`=0, `ovf_errOut`=0, `busyOut`=0. FIFO is empty, FSM is in IDLE, `cnt`=0.
- **Latency:** request accepted at edge T with the block idle and empty → valid is high in the cycle after edge T+LATENCY+1, for exactly one cycle. Default latency: edge T+4.
- **Throughput:** one response per LATENCY+1 cycles under continuous load. Responses are in strict acceptance order.
- **No response stall:** there is no response backpressure, so the consumer must sample on the valid cycle.
- **Reset mid-operation:** `Rst` asserted in any state immediately (asynchronously) clears FIFO, FSM and outputs. Pending requests are discarded with no response. The store is unaffected.

## Test plan
- Preload tag 1 = 0xDEADBEEF. Request tag 1 at edge 0 → valid high in cycle 4 only, tag 0x01, line 0xDEADBEEF; `busyOut` low from cycle 5.
- Preload tags 1/2/3 = 0xDEADBEEF/0xCAFEBABE/0xFEEDC0DE. Request all three on consecutive edges 0,1,2 → responses in cycles 4, 8 and 12, with tags 1,2,3 and matching data.
- Hold valid every cycle with tags 0..9 → ready drops exactly when count hits 4. Every accepted tag is answered in order; `ovf_errOut` stays 0 while the driver honours ready.
- Drive valid while ready is low → `ovf_errOut` rises on the next edge and stays 1. The dropped tag never appears on `mem_rspTagOut`.
- Request tag 5 (preloaded 0x11111111). Write 0x22222222 to tag 5 on the capture edge → response 0x11111111. Repeat the request → response 0x22222222.
- Request tag 2, assert `Rst` during WAIT → all outputs go to reset values immediately and no response follows. A new request after reset returns the preloaded tag 2 data unchanged.
